// File: rtl/config_frame_pkg.sv
// Shared definitions for the column configuration frame writer.
package config_frame_pkg;

    // Opcode carried in the top nibble of a write-frame header word
    localparam logic [3:0] WRITE_FRAME = 4'hF;

    // Header field positions and widths
    localparam int unsigned OP_LSB  = 28;
    localparam int unsigned OP_W    = 4;
    localparam int unsigned COL_LSB = 20;
    localparam int unsigned COL_W   = 8;
    localparam int unsigned IDX_LSB = 15;
    localparam int unsigned IDX_W   = 5;

    // Strobe-duration counter covers StrobeCycles up to 15
    localparam int unsigned STROBE_CNT_W = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_DATA,
        ST_SETUP,
        ST_STROBE,
        ST_HOLD,
        ST_SKIP
    } state_t;

endpackage

// File: rtl/config_frame_writer_if.sv
// Configuration word stream with valid/ready handshake.
interface config_frame_writer_if #(
    parameter int unsigned Width = 32
);
    logic [Width-1:0] data;
    logic             valid;
    logic             ready;

    modport master (output data, output valid, input ready);
    modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/frame_strobe_decode.sv
// Combinational frame index to one-hot strobe decoder; out-of-range index yields all zeros.
module frame_strobe_decode #(
    parameter int unsigned Width      = 20,
    parameter int unsigned IndexWidth = 5
) (
    input  logic [IndexWidth-1:0] index,
    input  logic                  en,
    output logic [Width-1:0]      onehot
);

    // One bit per frame line, gated by enable
    always_comb begin
        onehot = '0;
        for (int unsigned i = 0; i < Width; i++) begin
            onehot[i] = en && (32'(index) == i);
        end
    end

endmodule

// File: rtl/config_frame_writer.sv
// Decodes header+data word pairs and drives one column's FrameData / FrameStrobe
// with a setup, strobe, hold sequence.
module config_frame_writer
    import config_frame_pkg::*;
#(
    parameter int unsigned MaxFramesPerCol = 20,
    parameter int unsigned FrameBitsPerRow = 32,
    parameter int unsigned ColumnId        = 0,
    parameter int unsigned StrobeCycles    = 1,
    parameter int unsigned CountWidth      = 16
) (
    input  logic                        CLK,
    input  logic                        reset,
    config_frame_writer_if.slave        s,
    output logic [FrameBitsPerRow-1:0]  FrameData,
    output logic [MaxFramesPerCol-1:0]  FrameStrobe,
    output logic                        busy,
    output logic                        err,
    output logic [CountWidth-1:0]       frames_written
);

    state_t                      state_q, state_d;
    logic [COL_W-1:0]            col_q, col_d;
    logic [IDX_W-1:0]            idx_q, idx_d;
    logic [STROBE_CNT_W-1:0]     cnt_q, cnt_d;
    logic [FrameBitsPerRow-1:0]  data_q, data_d;
    logic [MaxFramesPerCol-1:0]  strobe_q, strobe_d;
    logic [CountWidth-1:0]       fw_q, fw_d;
    logic                        err_q, err_d;
    logic                        ready_q, ready_d;
    logic                        busy_q, busy_d;
    logic                        strobe_en;
    logic                        accept;
    logic [OP_W-1:0]             word_op;
    logic [COL_W-1:0]            word_col;
    logic [IDX_W-1:0]            word_idx;

    assign accept   = s.valid && ready_q;
    assign word_op  = s.data[OP_LSB  +: OP_W];
    assign word_col = s.data[COL_LSB +: COL_W];
    assign word_idx = s.data[IDX_LSB +: IDX_W];

    // Strobe decoder sees the latched index; its output is registered below
    frame_strobe_decode #(
        .Width      (MaxFramesPerCol),
        .IndexWidth (IDX_W)
    ) u_decode (
        .index  (idx_q),
        .en     (strobe_en),
        .onehot (strobe_d)
    );

    // Next-state and next-output logic
    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        err_d   = err_q;
        fw_d    = fw_q;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (word_op == WRITE_FRAME) begin
                        col_d   = word_col;
                        idx_d   = word_idx;
                        state_d = ST_WAIT_DATA;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_WAIT_DATA: begin
                if (accept) begin
                    state_d = ST_IDLE;
                    if (col_q == COL_W'(ColumnId)) begin
                        if (32'(idx_q) < MaxFramesPerCol) begin
                            data_d  = s.data;
                            state_d = ST_SETUP;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end
            end
            ST_SETUP: begin
                state_d = ST_STROBE;
                cnt_d   = '0;
                if (fw_q != {CountWidth{1'b1}}) begin
                    fw_d = fw_q + CountWidth'(1);
                end
            end
            ST_STROBE: begin
                if (cnt_q == STROBE_CNT_W'(StrobeCycles - 1)) begin
                    state_d = ST_HOLD;
                end else begin
                    cnt_d = cnt_q + STROBE_CNT_W'(1);
                end
            end
            ST_HOLD: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        strobe_en = (state_d == ST_STROBE);
        ready_d   = (state_d == ST_IDLE) || (state_d == ST_WAIT_DATA);
        busy_d    = (state_d != ST_IDLE);
    end

    // State and registered outputs
    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            col_q    <= '0;
            idx_q    <= '0;
            cnt_q    <= '0;
            data_q   <= '0;
            strobe_q <= '0;
            fw_q     <= '0;
            err_q    <= 1'b0;
            ready_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            col_q    <= col_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            data_q   <= data_d;
            strobe_q <= strobe_d;
            fw_q     <= fw_d;
            err_q    <= err_d;
            ready_q  <= ready_d;
            busy_q   <= busy_d;
        end
    end

    assign s.ready        = ready_q;
    assign FrameData      = data_q;
    assign FrameStrobe    = strobe_q;
    assign busy           = busy_q;
    assign err            = err_q;
    assign frames_written = fw_q;

endmodule

// File: tb/tb_config_frame_writer.sv
// Randomized bench for config_frame_writer against a timeline-based reference model.
module tb_config_frame_writer;

    localparam int unsigned MAX   = 20;
    localparam int unsigned FBW   = 32;
    localparam int unsigned COLID = 0;
    localparam int unsigned SC    = 3;
    localparam int unsigned CW    = 8;
    localparam int          SAT   = (1 << CW) - 1;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    config_frame_writer_if #(.Width(FBW)) bus ();

    logic [FBW-1:0] frame_data;
    logic [MAX-1:0] frame_strobe;
    logic           busy;
    logic           err;
    logic [CW-1:0]  frames_written;

    config_frame_writer #(
        .MaxFramesPerCol (MAX),
        .FrameBitsPerRow (FBW),
        .ColumnId        (COLID),
        .StrobeCycles    (SC),
        .CountWidth      (CW)
    ) dut (
        .CLK            (clk),
        .reset          (reset),
        .s              (bus),
        .FrameData      (frame_data),
        .FrameStrobe    (frame_strobe),
        .busy           (busy),
        .err            (err),
        .frames_written (frames_written)
    );

    // Rising-edge counter; the model is expressed in edge numbers
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: frame timeline anchored at the data-accept edge m_n
    int          rst_edge = 0;
    bit          m_act    = 1'b0;
    int          m_n      = 0;
    int unsigned m_aidx   = 0;
    int          m_base   = 0;
    bit          m_hdr    = 1'b0;
    bit          m_err    = 1'b0;
    logic [7:0]  m_col    = 8'h00;
    int unsigned m_idx    = 0;
    logic [31:0] m_fd     = 32'h0;
    bit          armed    = 1'b0;
    bit          last_acc = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s @edge %0d: got %h expected %h", tag, cyc, got, exp);
        end
    endtask

    function automatic bit in_frame(input int c);
        return m_act && (c < m_n + 2 + int'(SC));
    endfunction

    function automatic bit exp_ready(input int c);
        return (c > rst_edge) && !in_frame(c);
    endfunction

    task automatic check_all();
        int          c;
        int          cnt;
        logic [31:0] e_strobe;
        c        = cyc;
        e_strobe = (m_act && c >= m_n + 1 && c <= m_n + int'(SC)) ? (32'(1) << m_aidx) : 32'h0;
        cnt      = m_base + ((m_act && c >= m_n + 1) ? 1 : 0);
        if (cnt > SAT) cnt = SAT;
        check_eq("s_ready",        32'(bus.ready),      32'(exp_ready(c)));
        check_eq("busy",           32'(busy),           32'(m_hdr || in_frame(c)));
        check_eq("FrameStrobe",    32'(frame_strobe),   e_strobe);
        check_eq("FrameData",      frame_data,          m_fd);
        check_eq("err",            32'(err),            32'(m_err));
        check_eq("frames_written", 32'(frames_written), 32'(cnt));
    endtask

    // Advance the model across the coming edge given the inputs presented to it
    task automatic model_update(input bit r, input bit v, input logic [31:0] w);
        int c1;
        c1       = cyc + 1;
        last_acc = 1'b0;
        if (r) begin
            rst_edge = c1;
            m_act    = 1'b0;
            m_hdr    = 1'b0;
            m_err    = 1'b0;
            m_fd     = 32'h0;
            m_base   = 0;
        end else if (v && exp_ready(cyc)) begin
            last_acc = 1'b1;
            if (!m_hdr) begin
                if (w[31:28] == 4'hF) begin
                    m_hdr = 1'b1;
                    m_col = w[27:20];
                    m_idx = 32'(w[19:15]);
                end else begin
                    m_err = 1'b1;
                end
            end else begin
                m_hdr = 1'b0;
                if (m_col == 8'(COLID)) begin
                    if (m_idx < MAX) begin
                        if (m_act) m_base++;
                        m_act  = 1'b1;
                        m_n    = c1;
                        m_aidx = m_idx;
                        m_fd   = w;
                    end else begin
                        m_err = 1'b1;
                    end
                end
            end
        end
    endtask

    // One clock: check outputs, drive inputs for the next edge, advance the model
    task automatic step(input bit r, input bit v, input logic [31:0] w);
        if (armed) check_all();
        armed     = 1'b1;
        reset     = r;
        bus.valid = v;
        bus.data  = w;
        model_update(r, v, w);
        @(negedge clk);
    endtask

    task automatic send(input logic [31:0] w);
        int n;
        n = 0;
        do begin
            step(1'b0, 1'b1, w);
            n++;
        end while (!last_acc && n < 64);
        if (!last_acc) begin
            n_cmp++;
            n_bad++;
            $display("FAIL send_timeout @edge %0d: word %h not accepted within %0d cycles", cyc, w, n);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 1'b0, $urandom);
    endtask

    function automatic logic [31:0] hdr(input logic [7:0] col, input logic [4:0] idx);
        return {4'hF, col, idx, 15'(($urandom))};
    endfunction

    initial begin
        reset     = 1'b1;
        bus.valid = 1'b0;
        bus.data  = '0;
        @(negedge clk);
        repeat (3) step(1'b1, 1'b0, 32'h0);
        idle(2);

        // Basic frame at index 0
        send(32'hF000_0000);
        send(32'hDEAD_BEEF);
        idle(6);

        // Top index with valid dropped between header and data
        send(32'hF009_8000);
        idle(3);
        send(32'h1234_5678);
        idle(6);

        // Back-to-back frames with valid held during busy
        send(hdr(8'h00, 5'd1));
        send(32'hAAAA_5555);
        send(hdr(8'h00, 5'd2));
        send(32'h5555_AAAA);
        idle(6);

        // Column mismatch consumes data silently
        send(32'hF050_0000);
        send(32'hCAFE_F00D);
        idle(3);

        // Data word that looks like a header
        send(32'hF000_0000);
        send(32'hF123_4567);
        idle(6);

        // Out-of-range index sets sticky err
        send(32'hF00A_0000);
        send(32'h0BAD_0BAD);
        idle(3);
        send(hdr(8'h00, 5'd4));
        send(32'h0000_4444);
        idle(6);

        // Non-header word in IDLE after reset
        step(1'b1, 1'b0, 32'h0);
        idle(2);
        send(32'h0000_0001);
        idle(2);

        // Reset while the strobe is high
        step(1'b1, 1'b0, 32'h0);
        idle(1);
        send(32'hF002_8000);
        send(32'h7777_0000);
        step(1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b0, 32'h0);
        idle(3);

        // Randomized traffic
        for (int t = 0; t < 150; t++) begin
            if ($urandom_range(0, 9) == 0) begin
                send({4'($urandom_range(0, 14)), 28'($urandom)});
            end else begin
                logic [7:0] col;
                col = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'(COLID);
                send(hdr(col, 5'($urandom_range(0, 23))));
                idle($urandom_range(0, 2));
                send($urandom);
            end
            idle($urandom_range(0, 3));
        end

        // Counter saturation with back-to-back frames
        step(1'b1, 1'b0, 32'h0);
        idle(1);
        for (int t = 0; t < SAT + 5; t++) begin
            send(hdr(8'(COLID), 5'($urandom_range(0, MAX - 1))));
            send($urandom);
        end
        idle(6);
        check_eq("frames_sat", 32'(frames_written), 32'(SAT));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
